trip_time_fmt: RTL and testbench

//  Converts the binary trip-time count (seconds) from the trip-time accumulator into BCD HH:MM:SS

---
 rtl/trip_time_fmt.sv | 182 ++++++++++++++++++
 tb/tb_trip_time_fmt.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/trip_time_fmt.sv
// trip_time_fmt: binary seconds count -> BCD HH:MM:SS digits.
// Repeated-subtraction converter, one digit position per state, with a
// start/busy/done handshake. Inputs of 360000 s or more saturate the
// display at 99:59:59 and raise ovf.
module trip_time_fmt #(
    parameter int unsigned TIM_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [TIM_W-1:0] tim,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hh_t,
    output logic [3:0]       hh_o,
    output logic [3:0]       mm_t,
    output logic [3:0]       mm_o,
    output logic [3:0]       ss_t,
    output logic [3:0]       ss_o,
    output logic             ovf
);

    // Weight of one count in each digit position, in seconds.
    localparam logic [TIM_W-1:0] K_H10 = TIM_W'(36000);
    localparam logic [TIM_W-1:0] K_H1  = TIM_W'(3600);
    localparam logic [TIM_W-1:0] K_M10 = TIM_W'(600);
    localparam logic [TIM_W-1:0] K_M1  = TIM_W'(60);
    localparam logic [TIM_W-1:0] K_S10 = TIM_W'(10);
    // First value that no longer fits in 99:59:59.
    localparam logic [TIM_W-1:0] LIMIT = TIM_W'(360000);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        H10  = 3'd1,
        H1   = 3'd2,
        M10  = 3'd3,
        M1   = 3'd4,
        S10  = 3'd5,
        FIN  = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [TIM_W-1:0] rem;
    // Working digits in conversion order: h10, h1, m10, m1, s10.
    logic [3:0]       dig_h10;
    logic [3:0]       dig_h1;
    logic [3:0]       dig_m10;
    logic [3:0]       dig_m1;
    logic [3:0]       dig_s10;

    logic [TIM_W-1:0] k;
    logic             ge;
    logic             accept;
    logic             sat;

    // Weight for the digit position currently being resolved.
    always_comb begin
        k = '0;
        unique case (state)
            H10:     k = K_H10;
            H1:      k = K_H1;
            M10:     k = K_M10;
            M1:      k = K_M1;
            S10:     k = K_S10;
            default: k = '0;
        endcase
    end

    assign ge     = (rem >= k);
    assign accept = (state == IDLE) && start;
    assign sat    = (tim >= LIMIT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = sat ? FIN : H10;
                end
            end
            H10: begin
                busy = 1'b1;
                if (!ge) state_nx = H1;
            end
            H1: begin
                busy = 1'b1;
                if (!ge) state_nx = M10;
            end
            M10: begin
                busy = 1'b1;
                if (!ge) state_nx = M1;
            end
            M1: begin
                busy = 1'b1;
                if (!ge) state_nx = S10;
            end
            S10: begin
                busy = 1'b1;
                if (!ge) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Remainder and working digits: load on accept, subtract-and-count while converting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem     <= '0;
            dig_h10 <= '0;
            dig_h1  <= '0;
            dig_m10 <= '0;
            dig_m1  <= '0;
            dig_s10 <= '0;
        end else if (accept) begin
            rem     <= tim;
            dig_h10 <= '0;
            dig_h1  <= '0;
            dig_m10 <= '0;
            dig_m1  <= '0;
            dig_s10 <= '0;
        end else if (busy && ge) begin
            rem <= rem - k;
            unique case (state)
                H10:     dig_h10 <= dig_h10 + 4'd1;
                H1:      dig_h1  <= dig_h1  + 4'd1;
                M10:     dig_m10 <= dig_m10 + 4'd1;
                M1:      dig_m1  <= dig_m1  + 4'd1;
                S10:     dig_s10 <= dig_s10 + 4'd1;
                default: ;
            endcase
        end
    end

    // Published digits: updated only when entering FIN, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh_t <= '0;
            hh_o <= '0;
            mm_t <= '0;
            mm_o <= '0;
            ss_t <= '0;
            ss_o <= '0;
            ovf  <= 1'b0;
        end else if (accept && sat) begin
            hh_t <= 4'd9;
            hh_o <= 4'd9;
            mm_t <= 4'd5;
            mm_o <= 4'd9;
            ss_t <= 4'd5;
            ss_o <= 4'd9;
            ovf  <= 1'b1;
        end else if ((state == S10) && !ge) begin
            // What is left after the tens-of-seconds pass is below 10.
            hh_t <= dig_h10;
            hh_o <= dig_h1;
            mm_t <= dig_m10;
            mm_o <= dig_m1;
            ss_t <= dig_s10;
            ss_o <= rem[3:0];
            ovf  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trip_time_fmt.sv
// Scoreboard bench for trip_time_fmt: stimulus pushes expected digits,
// overflow flag and latency; the monitor checks each done pulse.
module tb_trip_time_fmt;

    localparam int unsigned TIM_W = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [TIM_W-1:0] tim;
    logic             busy;
    logic             done;
    logic [3:0]       hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
    logic             ovf;

    trip_time_fmt #(.TIM_W(TIM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .tim   (tim),
        .busy  (busy),
        .done  (done),
        .hh_t  (hh_t),
        .hh_o  (hh_o),
        .mm_t  (mm_t),
        .mm_o  (mm_o),
        .ss_t  (ss_t),
        .ss_o  (ss_o),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] digits;
        logic        ovf;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] shown();
        return {hh_t, hh_o, mm_t, mm_o, ss_t, ss_o};
    endfunction

    // Monitor: count busy cycles, and compare every done pulse with the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("digits", shown(), e.digits);
                    chk("ovf", ovf, e.ovf);
                    chk("latency", cyc - e.start_cyc, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat - 1);
                    chk("busy_at_done", busy, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Pulse start for one cycle; the cycle it is high in is cycle 0.
    task automatic issue(input logic [TIM_W-1:0] t, input logic [23:0] d,
                         input logic o, input int lat, output int s);
        exp_t e;
        @(posedge clk); #1;
        tim   = t;
        start = 1'b1;
        s     = cyc;
        e.digits = d; e.ovf = o; e.start_cyc = s; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [TIM_W-1:0] t;
        logic [23:0]      d;
        logic             o;
        int               lat;
    } vec_t;

    vec_t vecs[7] = '{
        '{20'd0,       24'h000000, 1'b0, 6},
        '{20'd3725,    24'h010205, 1'b0, 9},
        '{20'd359999,  24'h995959, 1'b0, 43},
        '{20'd360000,  24'h995959, 1'b1, 1},
        '{20'd1048575, 24'h995959, 1'b1, 1},
        '{20'd86399,   24'h235959, 1'b0, 30},
        '{20'd59,      24'h000059, 1'b0, 11}
    };

    initial begin
        int s;
        reset = 1'b1;
        start = 1'b0;
        tim   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_digits", shown(), 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].t, vecs[i].d, vecs[i].o, vecs[i].lat, s);
            drain();
        end

        // Start repeated while busy and in FIN, tim changed after accept.
        issue(20'd3725, 24'h010205, 1'b0, 9, s);
        @(posedge clk); #1;
        tim = 20'd59;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s + 9) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("hold_digits", shown(), 24'h010205);
        chk("hold_ovf", ovf, 0);

        // Reset in the middle of a long conversion.
        issue(20'd359999, 24'h995959, 1'b0, 43, s);
        while (cyc < s + 20) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_digits", shown(), 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        issue(20'd61, 24'h000101, 1'b0, 7, s);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
